rgb2ycbcr: RTL and testbench

Converts parallel 8-bit R/G/B pixels to a serialized 4:2:2 YCbCr byte stream (Cb, Y0, Cr, Y1) using BT.601 studio-range integer arithmetic. It is the encode-side counterpart of the display path's YCbCr-to-RGB converter: camera/test-pattern RGB enters here, and the byte stream leaves in the format the decoder consumes on `ycbcr_val`/`ycbcr_data`. Input is throttled with a ready signal so the input pixel rate matches the output byte rate.

---
 rtl/rgb2ycbcr.sv | 139 +++++++++++++
 tb/tb_rgb2ycbcr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr.sv
// RGB888 to 4:2:2 YCbCr (Cb,Y0,Cr,Y1) byte stream, BT.601 studio range.
// Odd pixel accepted in N -> Cb in N+4; rgb_rdy limits input to 1 pixel / 2 cycles, no output backpressure.
module rgb2ycbcr #(
  parameter int Y_MIN      = 16,
  parameter int Y_MAX      = 235,
  parameter int C_MIN      = 16,
  parameter int C_MAX      = 240,
  parameter bit CHROMA_AVG = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       r_val,
  input  logic [7:0] r_data,
  input  logic       g_val,
  input  logic [7:0] g_data,
  input  logic       b_val,
  input  logic [7:0] b_data,
  output logic       rgb_rdy,
  output logic       ycbcr_val,
  output logic [7:0] ycbcr_data
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic              accept;
  logic              v1, v2, v3;
  logic [7:0]        r1, g1, b1;
  logic signed [17:0] rs, gs, bs;
  logic signed [17:0] y_sum, cb_sum, cr_sum;
  logic [7:0]        y3, cb3, cr3;
  logic              phase;
  logic [7:0]        y0_hold, cb0_hold, cr0_hold;
  logic              load;
  logic [7:0]        cb_out, cr_out;
  state_t            state;
  logic [1:0]        cnt;
  logic [23:0]       shreg;

  function automatic logic [7:0] clamp8(input logic signed [17:0] v, input int lo, input int hi);
    if (v < $signed(18'(lo)))
      return 8'(lo);
    else if (v > $signed(18'(hi)))
      return 8'(hi);
    else
      return v[7:0];
  endfunction

  assign accept = r_val & g_val & b_val & rgb_rdy;
  assign rs = $signed({10'd0, r1});
  assign gs = $signed({10'd0, g1});
  assign bs = $signed({10'd0, b1});
  assign load = v3 & phase;

  // Rounded average of the held even-pixel chroma and the current odd-pixel chroma.
  assign cb_out = CHROMA_AVG ? 8'(({1'b0, cb0_hold} + {1'b0, cb3} + 9'd1) >> 1) : cb0_hold;
  assign cr_out = CHROMA_AVG ? 8'(({1'b0, cr0_hold} + {1'b0, cr3} + 9'd1) >> 1) : cr0_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_rdy <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      r1      <= 8'h00;
      g1      <= 8'h00;
      b1      <= 8'h00;
      y_sum   <= 18'sd0;
      cb_sum  <= 18'sd0;
      cr_sum  <= 18'sd0;
      y3      <= 8'h00;
      cb3     <= 8'h00;
      cr3     <= 8'h00;
    end else begin
      rgb_rdy <= ~accept;
      v1      <= accept;
      v2      <= v1;
      v3      <= v2;
      if (accept) begin
        r1 <= r_data;
        g1 <= g_data;
        b1 <= b_data;
      end
      if (v1) begin
        y_sum  <= 18'sd66 * rs + 18'sd129 * gs + 18'sd25 * bs + 18'sd128;
        cb_sum <= 18'sd112 * bs - 18'sd38 * rs - 18'sd74 * gs + 18'sd128;
        cr_sum <= 18'sd112 * rs - 18'sd94 * gs - 18'sd18 * bs + 18'sd128;
      end
      if (v2) begin
        y3  <= clamp8(18'sd16 + (y_sum >>> 8), Y_MIN, Y_MAX);
        cb3 <= clamp8(18'sd128 + (cb_sum >>> 8), C_MIN, C_MAX);
        cr3 <= clamp8(18'sd128 + (cr_sum >>> 8), C_MIN, C_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= 1'b0;
      y0_hold  <= 8'h00;
      cb0_hold <= 8'h00;
      cr0_hold <= 8'h00;
    end else if (v3) begin
      phase <= ~phase;
      if (!phase) begin
        y0_hold  <= y3;
        cb0_hold <= cb3;
        cr0_hold <= cr3;
      end
    end
  end

  // A load only ever lands in IDLE or on the 4th byte, so it may pre-empt SHIFT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      shreg      <= 24'h0;
      ycbcr_val  <= 1'b0;
      ycbcr_data <= 8'h00;
    end else if (load) begin
      state      <= SHIFT;
      cnt        <= 2'd0;
      shreg      <= {y0_hold, cr_out, y3};
      ycbcr_val  <= 1'b1;
      ycbcr_data <= cb_out;
    end else if (state == SHIFT) begin
      if (cnt == 2'd3) begin
        state      <= IDLE;
        ycbcr_val  <= 1'b0;
        ycbcr_data <= 8'h00;
      end else begin
        cnt        <= cnt + 2'd1;
        ycbcr_data <= shreg[23:16];
        shreg      <= {shreg[15:0], 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr.sv
// Random and directed stimulus for rgb2ycbcr, checked cycle-exactly against a pixel-level model.
module tb_rgb2ycbcr;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       r_val = 1'b0, g_val = 1'b0, b_val = 1'b0;
  logic [7:0] r_data = 8'h00, g_data = 8'h00, b_data = 8'h00;
  logic       rdy_a, rdy_b, val_a, val_b;
  logic [7:0] dat_a, dat_b;

  rgb2ycbcr #(.CHROMA_AVG(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .r_val(r_val), .r_data(r_data), .g_val(g_val), .g_data(g_data),
    .b_val(b_val), .b_data(b_data),
    .rgb_rdy(rdy_a), .ycbcr_val(val_a), .ycbcr_data(dat_a)
  );

  rgb2ycbcr #(.CHROMA_AVG(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .r_val(r_val), .r_data(r_data), .g_val(g_val), .g_data(g_data),
    .b_val(b_val), .b_data(b_data),
    .rgb_rdy(rdy_b), .ycbcr_val(val_b), .ycbcr_data(dat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
  } exp_t;

  exp_t exp_q[$];
  int   cap_a[$];
  int   cap_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   exp_rdy = 1'b0;
  bit   m_phase = 1'b0;
  int   m_y0, m_cb0, m_cr0;

  task automatic chk(input string tag, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", tag, cyc, got, expv);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void conv(input int r, input int g, input int b,
                               output int y, output int cb, output int cr);
    y  = clampi(16  + ((66 * r + 129 * g + 25 * b + 128) >>> 8), 16, 235);
    cb = clampi(128 + ((-38 * r - 74 * g + 112 * b + 128) >>> 8), 16, 240);
    cr = clampi(128 + ((112 * r - 94 * g - 18 * b + 128) >>> 8), 16, 240);
  endfunction

  // Pixel-level model: pairs pixels and schedules the 4 bytes 4..7 cycles after the odd accept.
  task automatic model_pixel(input int r, input int g, input int b, input int acc_cyc);
    int y, cb, cr;
    int cba, cra;
    exp_t e;
    conv(r, g, b, y, cb, cr);
    if (!m_phase) begin
      m_y0 = y; m_cb0 = cb; m_cr0 = cr;
    end else begin
      cba = (m_cb0 + cb + 1) / 2;
      cra = (m_cr0 + cr + 1) / 2;
      e.cyc = acc_cyc + 4; e.a = cba;  e.b = m_cb0; exp_q.push_back(e);
      e.cyc = acc_cyc + 5; e.a = m_y0; e.b = m_y0;  exp_q.push_back(e);
      e.cyc = acc_cyc + 6; e.a = cra;  e.b = m_cr0; exp_q.push_back(e);
      e.cyc = acc_cyc + 7; e.a = y;    e.b = y;     exp_q.push_back(e);
    end
    m_phase = ~m_phase;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit exp_v;
    bit acc;
    if (!reset_n) begin
      chk("rst_val", int'(val_a), 0);
      chk("rst_dat", int'(dat_a), 0);
      chk("rst_rdy", int'(rdy_a), 0);
      chk("rst_val_b", int'(val_b), 0);
      exp_q.delete();
      m_phase = 1'b0;
      exp_rdy = 1'b1;
    end else begin
      chk("rdy", int'(rdy_a), int'(exp_rdy));
      chk("rdy_b", int'(rdy_b), int'(exp_rdy));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("val", int'(val_a), int'(exp_v));
      chk("val_b", int'(val_b), int'(exp_v));
      if (exp_v) begin
        chk("dat", int'(dat_a), exp_q[0].a);
        chk("dat_b", int'(dat_b), exp_q[0].b);
        void'(exp_q.pop_front());
      end
      if (val_a) cap_a.push_back(int'(dat_a));
      if (val_b) cap_b.push_back(int'(dat_b));
      acc = r_val & g_val & b_val & rdy_a;
      if (acc) model_pixel(int'(r_data), int'(g_data), int'(b_data), cyc);
      exp_rdy = ~acc;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input int g, input int b, input bit hold);
    int n;
    r_data = 8'(r); g_data = 8'(g); b_data = 8'(b);
    r_val = 1'b1; g_val = 1'b1; b_val = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_a && n < 50);
    if (!rdy_a) chk("rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      r_val = 1'b0; g_val = 1'b0; b_val = 1'b0;
    end
  endtask

  task automatic expect_cap(input string tag, input logic [31:0] wa, input logic [31:0] wb);
    chk({tag, "_cnt"}, cap_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_a.size()) chk({tag, "_a"}, cap_a[i], int'(wa[31 - 8 * i -: 8]));
      if (i < cap_b.size()) chk({tag, "_b"}, cap_b[i], int'(wb[31 - 8 * i -: 8]));
    end
    cap_a.delete();
    cap_b.delete();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int n;
    #1;
    do_reset(3);
    cap_a.delete(); cap_b.delete();

    send(0, 0, 0, 1'b0);
    send(0, 0, 0, 1'b0);
    idle(8);
    expect_cap("black", 32'h80108010, 32'h80108010);

    send(255, 255, 255, 1'b0);
    send(255, 255, 255, 1'b0);
    idle(8);
    expect_cap("white", 32'h80EB80EB, 32'h80EB80EB);

    send(255, 0, 0, 1'b0);
    send(0, 0, 255, 1'b0);
    idle(8);
    expect_cap("redblue", 32'hA552AF29, 32'h5A52F029);

    for (int i = 0; i < 64; i++)
      send($urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b1);
    r_val = 1'b0; g_val = 1'b0; b_val = 1'b0;
    idle(10);
    chk("stream_cnt", cap_a.size(), 128);
    cap_a.delete(); cap_b.delete();

    r_val = 1'b1; g_val = 1'b0; b_val = 1'b1;
    idle(10);
    r_val = 1'b0; b_val = 1'b0;
    idle(6);
    chk("disagree_cnt", cap_a.size(), 0);

    send(10, 200, 30, 1'b0);
    idle(20);
    chk("trail_cnt", cap_a.size(), 0);
    send(90, 15, 220, 1'b0);
    idle(8);
    chk("trail_pair_cnt", cap_a.size(), 4);
    cap_a.delete(); cap_b.delete();

    send(40, 50, 60, 1'b0);
    send(70, 80, 90, 1'b0);
    idle(5);
    chk("pre_rst_val", int'(val_a), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_val", int'(val_a), 0);
    chk("mid_rst_dat", int'(dat_a), 0);
    chk("mid_rst_rdy", int'(rdy_a), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    idle(6);
    cap_a.delete(); cap_b.delete();
    send(1, 2, 3, 1'b0);
    idle(10);
    chk("even_after_rst", cap_a.size(), 0);
    send(250, 128, 7, 1'b0);
    idle(10);
    chk("pair_after_rst", cap_a.size(), 4);
    cap_a.delete(); cap_b.delete();

    for (int i = 0; i < 40; i++) begin
      send($urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b0);
      idle($urandom_range(3));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
